vlog_statmchs_sum_sched: RTL and testbench

Round-robin scheduler that shares one 3-operand, 8-bit summing engine between four requesters in the state-machine simulation suite. It arbitrates among pending requests, grants one requester at a time, and sequences exactly three operand beats from it into the internal accumulator. It returns the wrapped 8-bit sum with a one-cycle valid pulse and the winner's ID. It is the controller layer above the sum-three datapath: start/ready semantics are kept, operand sourcing is time-shared.

---
 rtl/vlog_statmchs_sum_sched_if.sv | 33 +++
 rtl/vlog_statmchs_sum_sched.sv | 145 ++++++++++++++
 tb/tb_vlog_statmchs_sum_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vlog_statmchs_sum_sched_if.sv
// Requester-side bundle for the shared three-operand summing engine.
// Carries the requests, operand beats, grants and the result.
interface vlog_statmchs_sum_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: req[i] is a level held until the transaction completes or
  // aborts. An operand beat transfers at a rising edge where
  // din_valid[i] && din_ack[i]; din_ack is only ever set for the granted
  // requester. sum/sum_id are meaningful only in the cycle sum_valid is high.
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0]   din_valid;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   din_ack;
  logic [W-1:0]      sum;
  logic              sum_valid;
  logic [IDW-1:0]    sum_id;
  logic              ready;
  logic              busy;

  modport master (
    output req, din, din_valid,
    input  gnt, din_ack, sum, sum_valid, sum_id, ready, busy
  );

  modport slave (
    input  req, din, din_valid,
    output gnt, din_ack, sum, sum_valid, sum_id, ready, busy
  );
endinterface

// File: rtl/vlog_statmchs_sum_sched.sv
// Round-robin scheduler sharing one NOPS-operand W-bit summing engine
// between NREQ requesters; returns the wrapped sum with the winner's ID.
module vlog_statmchs_sum_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int NOPS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  vlog_statmchs_sum_sched_if.slave      bus,
  output logic [1:0]                    state_o
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(NOPS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IDW-1:0]  sum_id_q, sum_id_d;
  logic            sum_valid_q, sum_valid_d;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  rr_idx;
  logic [W-1:0]    opnd;
  logic            beat;
  logic            last_beat;
  logic [W-1:0]    acc_sum;

  // Search starts just after the last grant, so a repeat requester ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = IDW'((int'(last_q) + k) % NREQ);
      if (!win_found && bus.req[rr_idx]) begin
        win_found = 1'b1;
        win_id    = rr_idx;
      end
    end
  end

  always_comb begin
    opnd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (id_q == IDW'(i)) opnd = bus.din[i*W +: W];
    end
  end

  assign beat      = (state_q == S_ACCUM) && bus.din_valid[id_q];
  assign last_beat = beat && (cnt_q == CW'(NOPS - 1));
  // The first beat overwrites whatever an earlier or aborted transaction left.
  assign acc_sum   = ((cnt_q == '0) ? '0 : acc_q) + opnd;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    id_d        = id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_id_d    = sum_id_q;
    sum_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d         = '0;
          gnt_d[win_id] = 1'b1;
          id_d          = win_id;
          last_d        = win_id;
          cnt_d         = '0;
          state_d       = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // A final beat completes even if req drops in the same cycle.
        if (last_beat) begin
          acc_d       = acc_sum;
          sum_d       = acc_sum;
          sum_id_d    = id_q;
          sum_valid_d = 1'b1;
          cnt_d       = cnt_q + CW'(1);
          gnt_d       = '0;
          state_d     = S_DONE;
        end else if (!bus.req[id_q]) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (beat) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      id_q        <= '0;
      last_q      <= IDW'(NREQ - 1);
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_id_q    <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      id_q        <= id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_id_q    <= sum_id_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.din_ack   = (state_q == S_ACCUM) ? (gnt_q & bus.din_valid) : '0;
  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_id    = sum_id_q;
  assign bus.ready     = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign state_o       = state_q;
endmodule

// File: tb/tb_vlog_statmchs_sum_sched.sv
// Scoreboard bench for the round-robin sum scheduler: directed scenarios
// followed by randomized request/operand/stall traffic.
module tb_vlog_statmchs_sum_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  vlog_statmchs_sum_sched_if #(.NREQ(NREQ), .W(W)) bus ();
  logic [1:0] state_dbg;

  vlog_statmchs_sum_sched #(.NREQ(NREQ), .W(W), .NOPS(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_dbg)
  );

  int vectors = 0;
  int errors  = 0;
  logic [IDW+W-1:0] exp_q[$];
  int         last_m;       // model: most recently granted requester
  logic [7:0] last_sum_m;   // model: sum currently held on the output
  int         gnt_cyc;
  bit         got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin reference: first requester after 'last' in circular order.
  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.sum_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_sum_valid: got id=%0d sum=%0d expected no result", bus.sum_id, bus.sum);
      end else begin
        check("sum_result", {bus.sum_id, bus.sum}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic junk_others(input int w);
    for (int i = 0; i < NREQ; i++) begin
      if (i != w) begin
        bus.din[i*W +: W] = 8'($urandom);
        bus.din_valid[i]  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("gnt_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_txn(input int w, input logic [7:0] o0, input logic [7:0] o1,
                        input logic [7:0] o2, input int s0, input int s1, input int s2,
                        input bit drop_at_last, input bit drop_after);
    logic [7:0] ops[3];
    int         st[3];
    logic [7:0] s;
    bit         ok;
    ops = '{o0, o1, o2};
    st  = '{s0, s1, s2};
    s   = o0 + o1 + o2;
    exp_q.push_back({IDW'(w), s});
    last_sum_m = s;
    wait_gnt(ok);
    gnt_cyc = cyc;
    check("gnt_onehot", {28'd0, bus.gnt}, 32'd1 << w);
    check("busy_accum", {30'd0, bus.ready, bus.busy}, 32'b01);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < st[b]; k++) begin
        junk_others(w);
        bus.din_valid[w] = 1'b0;
        #1 check("ack_stall", {28'd0, bus.din_ack}, 32'd0);
        @(negedge clk);
      end
      junk_others(w);
      bus.din[w*W +: W] = ops[b];
      bus.din_valid[w]  = 1'b1;
      if (b == 2 && drop_at_last) bus.req[w] = 1'b0;
      #1 check("ack_beat", {28'd0, bus.din_ack}, 32'd1 << w);
      @(negedge clk);
    end
    bus.din_valid = '0;
    check("gnt_done", {28'd0, bus.gnt}, 32'd0);
    check("sum_valid_pulse", {31'd0, bus.sum_valid}, 32'd1);
    check("busy_done", {30'd0, bus.ready, bus.busy}, 32'b01);
    if (drop_after) bus.req[w] = 1'b0;
    last_m = w;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int prev_cyc;
    reset = 1'b0;
    bus.req = '0;
    bus.din = '0;
    bus.din_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    check("rst_ack", {28'd0, bus.din_ack}, 32'd0);
    check("rst_sum", {24'd0, bus.sum}, 32'd0);
    check("rst_sum_valid", {31'd0, bus.sum_valid}, 32'd0);
    check("rst_sum_id", {30'd0, bus.sum_id}, 32'd0);
    check("rst_ready_busy", {30'd0, bus.ready, bus.busy}, 32'b10);
    bus.din_valid = '0;
    reset = 1'b1;
    last_m = NREQ - 1;
    last_sum_m = 8'd0;

    // single requester
    bus.req = 4'b0001;
    w = rr_pick(last_m, bus.req);
    do_txn(w, 8'd10, 8'd20, 8'd30, 0, 0, 0, 1'b0, 1'b1);

    // wrap-around sum
    bus.req = 4'b0100;
    do_txn(rr_pick(last_m, bus.req), 8'd200, 8'd100, 8'd5, 0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("idle_ready", {30'd0, bus.ready, bus.busy}, 32'b10);
    check("sum_held", {24'd0, bus.sum}, {24'd0, last_sum_m});

    // fairness with all requesters held, back-to-back spacing
    bus.req = 4'b1111;
    prev_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      do_txn(rr_pick(last_m, bus.req), 8'd1, 8'd2, 8'd3, 0, 0, 0, 1'b0, 1'b0);
      if (n > 0) check("grant_spacing", gnt_cyc - prev_cyc, 32'd5);
      prev_cyc = gnt_cyc;
    end
    bus.req = '0;

    // stall in the middle
    bus.req = 4'b0010;
    do_txn(rr_pick(last_m, bus.req), 8'd7, 8'd8, 8'd9, 0, 4, 0, 1'b0, 1'b1);

    // abort after one beat from requester 3
    bus.req = 4'b1000;
    wait_gnt(got);
    check("abort_gnt", {28'd0, bus.gnt}, 32'b1000);
    bus.din[3*W +: W] = 8'd50;
    bus.din_valid[3] = 1'b1;
    @(negedge clk);
    bus.din_valid = '0;
    bus.req[3] = 1'b0;
    @(negedge clk);
    check("abort_gnt_clear", {28'd0, bus.gnt}, 32'd0);
    check("abort_ready", {30'd0, bus.ready, bus.busy}, 32'b10);
    check("abort_sum_held", {24'd0, bus.sum}, {24'd0, last_sum_m});
    last_m = 3;
    bus.req = 4'b1001;
    do_txn(rr_pick(last_m, bus.req), 8'd11, 8'd22, 8'd33, 0, 1, 0, 1'b0, 1'b1);
    do_txn(rr_pick(last_m, bus.req), 8'd50, 8'd60, 8'd70, 0, 0, 0, 1'b0, 1'b1);

    // req drops together with the final beat
    bus.req = 4'b0100;
    do_txn(rr_pick(last_m, bus.req), 8'd90, 8'd90, 8'd90, 0, 0, 0, 1'b1, 1'b0);

    // reset mid-transaction
    bus.req = 4'b0010;
    wait_gnt(got);
    bus.din[1*W +: W] = 8'd40;
    bus.din_valid[1] = 1'b1;
    @(negedge clk);
    bus.din[1*W +: W] = 8'd41;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_gnt", {28'd0, bus.gnt}, 32'd0);
    check("mid_rst_ready", {30'd0, bus.ready, bus.busy}, 32'b10);
    check("mid_rst_sum", {24'd0, bus.sum}, 32'd0);
    check("mid_rst_sum_valid", {31'd0, bus.sum_valid}, 32'd0);
    check("mid_rst_ack", {28'd0, bus.din_ack}, 32'd0);
    bus.din_valid = '0;
    reset = 1'b1;
    last_m = NREQ - 1;
    last_sum_m = 8'd0;
    bus.req = 4'b1111;
    w = rr_pick(last_m, bus.req);
    do_txn(w, 8'd3, 8'd4, 8'd5, 0, 0, 0, 1'b0, 1'b0);
    bus.req = '0;

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      bus.req = 4'($urandom_range(1, 15));
      for (int g = 0; g < 8 && bus.req != '0; g++) begin
        do_txn(rr_pick(last_m, bus.req), 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end
      bus.req = '0;
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("final_sum_held", {24'd0, bus.sum}, {24'd0, last_sum_m});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
